// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative multiply / multiply-accumulate / restoring divide unit
module muldiv_iter #(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 start,
   input  logic [2:0]           op,
   input  logic [WIDTH-1:0]     operand_1,
   input  logic [WIDTH-1:0]     operand_2,
   input  logic [WIDTH-1:0]     hi,
   input  logic [WIDTH-1:0]     lo,
   output logic                 ready,
   output logic                 done,
   output logic                 div_zero,
   output logic [2*WIDTH-1:0]   result
);
   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + MUL_LATENCY + 1);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t           state;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] mag_1, mag_2;
   logic             sign_1, sign_2;
   logic [W2-1:0]    acc, prod;
   logic [WIDTH-1:0] rem, quo;
   logic [CW-1:0]    cnt;

   logic             in_signed, in_sign_1, in_sign_2, in_div;
   logic [WIDTH-1:0] in_mag_1, in_mag_2;
   logic [WIDTH:0]   shifted, trial;
   logic [W2-1:0]    prod_s, fix_val;
   logic [WIDTH-1:0] quo_s, rem_s;

   always_comb begin
      in_signed = ~op[0];
      in_sign_1 = in_signed & operand_1[WIDTH-1];
      in_sign_2 = in_signed & operand_2[WIDTH-1];
      in_mag_1  = in_sign_1 ? -operand_1 : operand_1;
      in_mag_2  = in_sign_2 ? -operand_2 : operand_2;
      in_div    = (op[2:1] == 2'b01);
   end

   // Restoring step: a borrow in the top bit means the divisor did not fit.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, mag_2};
   end

   always_comb begin
      prod_s = (sign_1 ^ sign_2) ? -prod : prod;
      quo_s  = (sign_1 ^ sign_2) ? -quo : quo;
      rem_s  = sign_1 ? -rem : rem;
      case (op_r)
         3'd2, 3'd3: fix_val = {rem_s, quo_s};
         3'd4, 3'd5: fix_val = acc + prod_s;
         3'd6, 3'd7: fix_val = acc - prod_s;
         default:    fix_val = prod_s;
      endcase
   end

   assign ready = (state == S_IDLE) || (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         done     <= 1'b0;
         div_zero <= 1'b0;
         result   <= '0;
         op_r     <= '0;
         mag_1    <= '0;
         mag_2    <= '0;
         sign_1   <= 1'b0;
         sign_2   <= 1'b0;
         acc      <= '0;
         prod     <= '0;
         rem      <= '0;
         quo      <= '0;
         cnt      <= '0;
      end else if (flush) begin
         state <= S_IDLE;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  op_r     <= op;
                  mag_1    <= in_mag_1;
                  mag_2    <= in_mag_2;
                  sign_1   <= in_sign_1;
                  sign_2   <= in_sign_2;
                  acc      <= {hi, lo};
                  rem      <= '0;
                  quo      <= in_mag_1;
                  div_zero <= 1'b0;
                  cnt      <= in_div ? CW'(WIDTH - 1) : CW'(MUL_LATENCY - 1);
                  state    <= in_div ? S_DIV : S_MUL;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_MUL: begin
               prod <= W2'(mag_1) * W2'(mag_2);
               if (cnt == '0) state <= S_FIX;
               else           cnt   <= cnt - 1'b1;
            end
            S_DIV: begin
               rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
               if (cnt == '0) state <= S_FIX;
               else           cnt   <= cnt - 1'b1;
            end
            S_FIX: begin
               result   <= fix_val;
               div_zero <= (op_r[2:1] == 2'b01) && (mag_2 == '0);
               done     <= 1'b1;
               state    <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - scoreboard bench for muldiv_iter (32-bit default and 8-bit/latency-4 instances)
module tb_muldiv_iter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst_v, flush_v, start_v, ready_v, done_v, dz_v;
   logic [2:0]  op_v [2];
   logic [31:0] opa [2], opb [2], hi_v [2], lo_v [2];
   logic [63:0] res0;
   logic [15:0] res1;

   int checks = 0, errors = 0, cyc = 0;

   typedef struct {logic [63:0] res; logic dz; int due;} exp_t;
   exp_t        sb [2][$];
   exp_t        mon_e;
   logic [63:0] last_res [2];

   muldiv_iter #(.WIDTH(32), .MUL_LATENCY(1)) dut0 (
      .clk(clk), .rst(rst_v[0]), .flush(flush_v[0]), .start(start_v[0]), .op(op_v[0]),
      .operand_1(opa[0]), .operand_2(opb[0]), .hi(hi_v[0]), .lo(lo_v[0]),
      .ready(ready_v[0]), .done(done_v[0]), .div_zero(dz_v[0]), .result(res0));

   muldiv_iter #(.WIDTH(8), .MUL_LATENCY(4)) dut1 (
      .clk(clk), .rst(rst_v[1]), .flush(flush_v[1]), .start(start_v[1]), .op(op_v[1]),
      .operand_1(opa[1][7:0]), .operand_2(opb[1][7:0]), .hi(hi_v[1][7:0]), .lo(lo_v[1][7:0]),
      .ready(ready_v[1]), .done(done_v[1]), .div_zero(dz_v[1]), .result(res1));

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int wid(int d);
      return (d == 0) ? 32 : 8;
   endfunction

   function automatic int lat(int d);
      return (d == 0) ? 1 : 4;
   endfunction

   function automatic logic [63:0] getres(int d);
      return (d == 0) ? res0 : {48'b0, res1};
   endfunction

   task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] sx(logic [63:0] v, int w, bit s);
      if (s && v[w-1]) return v | ~((64'd1 << w) - 1);
      return v;
   endfunction

   // Reference: plain signed/unsigned integer arithmetic, result {div_zero, value}.
   function automatic logic [64:0] model(int w, logic [2:0] o, logic [63:0] a, logic [63:0] b,
                                         logic [63:0] h, logic [63:0] l);
      bit          s   = !o[0];
      logic [63:0] mw  = (64'd1 << w) - 1;
      logic [63:0] m2  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (2 * w)) - 1;
      logic [63:0] ua  = sx(a, w, s);
      logic [63:0] ub  = sx(b, w, s);
      logic [63:0] acc = (h << w) | l;
      logic [63:0] p, q, r;
      longint      na, nb;
      na = $signed(ua);
      nb = $signed(ub);
      if (o[2:1] == 2'b01) begin
         if (b == 0) begin
            q = (s && a[w-1]) ? 64'd1 : mw;
            r = a;
         end else if (s) begin
            q = na / nb;
            r = na % nb;
         end else begin
            q = a / b;
            r = a % b;
         end
         return {(b == 0), ((r & mw) << w) | (q & mw)};
      end
      p = ua * ub;
      if (o[2:1] == 2'b10) p = acc + p;
      else if (o[2:1] == 2'b11) p = acc - p;
      return {1'b0, p & m2};
   endfunction

   function automatic logic [63:0] pick(int w);
      logic [63:0] mw = (64'd1 << w) - 1;
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return mw;
         2:       return 64'd1 << (w - 1);
         3:       return 64'd1;
         default: return {32'b0, $urandom} & mw;
      endcase
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (done_v[d]) begin
            if (sb[d].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done dut%0d: got done=1 expected no pending op (cycle %0d)", d, cyc);
            end else begin
               mon_e = sb[d].pop_front();
               chk("result", d, getres(d), mon_e.res);
               chk("div_zero", d, {63'b0, dz_v[d]}, {63'b0, mon_e.dz});
               chk("done_latency", d, cyc, mon_e.due);
               last_res[d] = mon_e.res;
            end
         end else if (sb[d].size() != 0) begin
            chk("ready_busy", d, {63'b0, ready_v[d]}, 64'd0);
            if (cyc > sb[d][0].due) begin
               checks++;
               errors++;
               $display("FAIL done_missing dut%0d: got no done by cycle %0d expected at %0d", d, cyc, sb[d][0].due);
               void'(sb[d].pop_front());
            end
         end
      end
   end

   // Call at a negedge; drives start for one edge, then scrambles the operand inputs.
   task automatic issue(input int d, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l, input logic [63:0] er,
                        input logic edz, input bit exp_acc);
      bit acc;
      op_v[d] = o; opa[d] = a; opb[d] = b; hi_v[d] = h; lo_v[d] = l;
      start_v[d] = 1'b1;
      acc = ready_v[d] && !flush_v[d];
      chk("accept", d, {63'b0, acc}, {63'b0, exp_acc});
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
      opa[d] = $urandom; opb[d] = $urandom; hi_v[d] = $urandom; lo_v[d] = $urandom;
      if (acc) sb[d].push_back('{er, edz, cyc + ((o[2:1] == 2'b01) ? wid(d) : lat(d)) + 1});
   endtask

   task automatic wait_idle(input int d);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (ready_v[d] && sb[d].size() == 0) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout dut%0d: got busy after 100 cycles expected idle", d);
         sb[d].delete();
      end
   endtask

   task automatic wait_done(input int d);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done_v[d]) break;
      end
   endtask

   task automatic rand_op(input int d);
      int          w = wid(d);
      logic [2:0]  o = 3'($urandom_range(0, 7));
      logic [63:0] a = pick(w), b = pick(w), h = pick(w), l = pick(w);
      logic [64:0] m = model(w, o, a, b, h, l);
      @(negedge clk);
      issue(d, o, a[31:0], b[31:0], h[31:0], l[31:0], m[63:0], m[64], 1'b1);
      wait_idle(d);
   endtask

   task automatic check_reset_outputs(input int d);
      chk("rst_ready", d, {63'b0, ready_v[d]}, 64'd1);
      chk("rst_done", d, {63'b0, done_v[d]}, 64'd0);
      chk("rst_div_zero", d, {63'b0, dz_v[d]}, 64'd0);
      chk("rst_result", d, getres(d), 64'd0);
   endtask

   initial begin
      rst_v = 2'b11; flush_v = 2'b00; start_v = 2'b00;
      for (int d = 0; d < 2; d++) begin
         op_v[d] = '0; opa[d] = '0; opb[d] = '0; hi_v[d] = '0; lo_v[d] = '0; last_res[d] = '0;
      end
      repeat (3) @(negedge clk);
      check_reset_outputs(0);
      check_reset_outputs(1);
      rst_v = 2'b00;

      @(negedge clk); issue(0, 3'd0, -32'sd3, 32'd7, 0, 0, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b1);
      wait_idle(0);
      @(negedge clk); issue(0, 3'd3, 32'd100, 32'd7, 0, 0, 64'h00000002_0000000E, 1'b0, 1'b1);
      wait_done(0);
      issue(0, 3'd2, -32'sd100, 32'd7, 0, 0, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 1'b1);
      wait_idle(0);
      @(negedge clk); issue(0, 3'd2, 32'd5, 32'd0, 0, 0, 64'h00000005_FFFFFFFF, 1'b1, 1'b1);
      wait_idle(0);
      @(negedge clk); issue(0, 3'd1, 32'd2, 32'd3, 0, 0, 64'd6, 1'b0, 1'b1);
      wait_idle(0);
      @(negedge clk); issue(0, 3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 64'h00000001_00000000, 1'b0, 1'b1);
      wait_idle(0);
      @(negedge clk); issue(0, 3'd7, 32'd2, 32'd3, 0, 0, 64'hFFFFFFFF_FFFFFFFA, 1'b0, 1'b1);
      wait_idle(0);

      // start while busy must be ignored
      @(negedge clk); issue(0, 3'd1, 32'd5, 32'd5, 0, 0, 64'd25, 1'b0, 1'b1);
      @(negedge clk); issue(0, 3'd0, 32'd9, 32'd9, 0, 0, 64'd81, 1'b0, 1'b0);
      wait_idle(0);

      // flush ten cycles into a divide
      @(negedge clk); issue(0, 3'd3, 32'd1000, 32'd3, 0, 0, 64'h00000001_0000014D, 1'b0, 1'b1);
      repeat (9) @(negedge clk);
      flush_v[0] = 1'b1;
      @(posedge clk); #1;
      flush_v[0] = 1'b0;
      sb[0].delete();
      @(negedge clk);
      chk("flush_ready", 0, {63'b0, ready_v[0]}, 64'd1);
      chk("flush_done", 0, {63'b0, done_v[0]}, 64'd0);
      chk("flush_result", 0, res0, 64'd25);
      repeat (40) @(negedge clk);

      // flush beats start in the same cycle
      flush_v[0] = 1'b1;
      issue(0, 3'd1, 32'd3, 32'd3, 0, 0, 64'd9, 1'b0, 1'b0);
      flush_v[0] = 1'b0;
      repeat (6) @(negedge clk);
      chk("flush_start_result", 0, res0, 64'd25);

      @(negedge clk); issue(1, 3'd0, 32'h80, 32'h80, 0, 0, 64'h4000, 1'b0, 1'b1);
      wait_idle(1);
      @(negedge clk); issue(1, 3'd2, 32'h80, 32'hFF, 0, 0, 64'h0080, 1'b0, 1'b1);
      wait_idle(1);

      // reset in the middle of a multiply
      @(negedge clk); issue(1, 3'd1, 32'd3, 32'd5, 0, 0, 64'd15, 1'b0, 1'b1);
      @(negedge clk); @(negedge clk);
      rst_v[1] = 1'b1;
      @(posedge clk); #1;
      rst_v[1] = 1'b0;
      sb[1].delete();
      @(negedge clk);
      check_reset_outputs(1);
      repeat (8) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         rand_op(0);
         rand_op(1);
      end

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
